cle_key_prober: RTL and testbench
=================================

// Module: cle_key_prober
// PURPOSE
//  Host-side initiator for the CLE0a1 key responder. Drives the select, address (BA13/BA12/BA7..4)
//  and R/W lines, clocks the responder one step per command nibble, and captures the two
//  response lines (SDRD, RSP) after each step. Sits between the host command interface and the
//  key socket pins. Each captured bit pair is returned to the host for challenge/response checking.
// PARAMETERS
//  RST_CYC  4  cycles key_sel_n held high before a sequence (responder state clears when deselected)
//  SETTLE   2  clk cycles per phase (address setup, key_clk high, key_clk low/settle); range 1..15
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  1-cycle pulse: begin sequence; ignored while busy
//  n_steps      in   6  number of responder steps in the sequence (sampled on start)
//  abort        in   1  terminate sequence; deselects the responder
//  cmd_valid    in   1  cmd_nib is valid
//  cmd_nib      in   4  address nibble for the next step -> BA7..BA4
//  cmd_ready    out  1  nibble accepted this cycle (valid & ready)
//  rsp_valid    out  1  1-cycle pulse: rsp_bits updated
//  rsp_bits     out  2  {RSP, SDRD} sampled after the step
//  busy         out  1  sequence in progress
//  done         out  1  1-cycle pulse at end of sequence (normal or aborted)
//  key_sel_n    out  1  SSER, active low
//  key_ba13     out  1  BA13; 0 while selected
//  key_ba12     out  1  BA12; 1 while selected
//  key_nib      out  4  BA7..BA4
//  key_rw       out  1  BR_W; 1 while selected
//  key_clk      out  1  responder clock; responder registers on rising edge
//  key_sdrd_i   in   1  responder SDRD (pulled high when undriven)
//  key_rsp_i    in   1  responder RSP line (pulled high when undriven)
// BEHAVIOUR
//  Reset: state IDLE; key_sel_n=1, key_ba13=1, key_ba12=0, key_nib=0, key_rw=0, key_clk=0;
//   busy=0, done=0, rsp_valid=0, rsp_bits=2'b11, cmd_ready=0, step counter 0.
//  FSM: IDLE -start-> DESEL(RST_CYC cyc, sel_n=1, key_clk=0) -> SELECT(1 cyc: sel_n=0, ba13=0, ba12=1, rw=1)
//   -> WAIT_CMD -> SETUP(SETTLE) -> CLK_HI(SETTLE) -> CLK_LO(SETTLE) -> SAMPLE(1) -> WAIT_CMD | FINISH -> IDLE.
//  WAIT_CMD: cmd_ready=1; on cmd_valid latch nibble into key_nib, go SETUP. No nibble: wait
//   indefinitely, select held, key_clk low (responder state preserved).
//  Select and address lines constant from SELECT to FINISH; only key_nib and key_clk change.
//  key_nib changes only in the cycle entering SETUP (stable across the key_clk rising edge).
//  SAMPLE: rsp_bits <= {key_rsp_i, key_sdrd_i} (2-flop synchronised inputs); rsp_valid=1 that cycle;
//   step counter +1; counter == n_steps -> FINISH, else WAIT_CMD.
//  FINISH: done=1 one cycle, key_sel_n=1, key_ba13=1, key_ba12=0, key_rw=0; busy falls next cycle.
//  Step latency: cmd accept -> rsp_valid = 3*SETTLE+1 cycles (+2 sync, counted inside CLK_LO span).
//  n_steps=0: DESEL, SELECT, FINISH; no key_clk pulse, no rsp_valid.
//  abort (any busy state): next cycle key_clk=0, sel_n=1, FINISH; in-flight step not sampled.
//  abort and start same cycle in IDLE: abort wins, nothing starts. start while busy: ignored.
//  rst_n low mid-sequence: all outputs to reset values asynchronously; responder therefore deselected.
//  Counter 6 bits, n_steps max 63; no wrap possible.
// STRUCTURE
//  cle_pkg: state enum, KEY_BA13_SEL=0, KEY_BA12_SEL=1, KEY_RW_SEL=1, default RST_CYC/SETTLE.
//  Sub-module cle_phase_timer: 4-bit down-counter, load/expire, shared by DESEL and phase states.
//  Input synchronisers inline (2 flops each, reset to 1).
// TESTING (bench includes behavioural responder model of the key state machine)
//  1 Reset: rst_n low -> key_sel_n=1, key_clk=0, rsp_bits=2'b11, busy=0 all cycles.
//  2 start, n_steps=3, nibbles 4'h2,4'hA,4'h9 -> 3 key_clk pulses, 3 rsp_valid, bits match model, done once.
//  3 cmd_valid withheld 20 cycles after step 1 -> key_clk low, sel_n=0 held, step 2 response matches model.
//  4 abort during CLK_HI of step 2 -> no rsp_valid for step 2, done pulse, key_sel_n=1 next cycle.
//  5 n_steps=0 -> no key_clk edge, done after RST_CYC+2 cycles.
//  6 rst_n low during CLK_LO -> immediate deselect; new start -> model restarts from state 0.

Source files
------------

// File: rtl/cle_pkg.sv
// ----------------------------------------------------------------------------
// cle_pkg
//   Shared definitions for the CLE0a1 key prober: controller state encoding,
//   the address/control levels driven while the responder is selected, and
//   default timing parameters.
// ----------------------------------------------------------------------------
package cle_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DESEL    = 4'd1,
        ST_SELECT   = 4'd2,
        ST_WAIT_CMD = 4'd3,
        ST_SETUP    = 4'd4,
        ST_CLK_HI   = 4'd5,
        ST_CLK_LO   = 4'd6,
        ST_SAMPLE   = 4'd7,
        ST_FINISH   = 4'd8
    } cle_state_e;

    // Pin levels while the responder is selected
    localparam logic KEY_BA13_SEL = 1'b0;
    localparam logic KEY_BA12_SEL = 1'b1;
    localparam logic KEY_RW_SEL   = 1'b1;

    // Deselect time before a sequence and per-phase length, in clk cycles.
    // Both must fit the 4-bit phase timer (1..15).
    localparam int unsigned CLE_RST_CYC_DEF = 4;
    localparam int unsigned CLE_SETTLE_DEF  = 2;

endpackage

// File: rtl/cle_phase_timer.sv
// ----------------------------------------------------------------------------
// cle_phase_timer
//   4-bit down-counter that times one controller state. The owner pulses
//   'load' in the first cycle of a timed state; 'expired' is high in the last
//   cycle of a span of load_val cycles (load_val >= 1).
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   load      in   first cycle of a timed span
//   load_val  in   span length in cycles
//   expired   out  last cycle of the span (combinational)
// ----------------------------------------------------------------------------
module cle_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expired
);

    logic [3:0] cnt;

    // cnt holds the cycles remaining after the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val - 4'd1;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // A one-cycle span expires in its load cycle
    assign expired = load ? (load_val <= 4'd1) : (cnt == 4'd1);

endmodule

// File: rtl/cle_key_prober.sv
// ----------------------------------------------------------------------------
// cle_key_prober
//   Host-side initiator for the CLE0a1 key responder. Selects the responder,
//   steps it once per host command nibble (nibble on BA7..BA4, one key_clk
//   pulse) and returns the captured {RSP, SDRD} pair after every step.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | responder deselected, waiting for start
//   DESEL      | RST_CYC cycles deselected so the responder clears
//   SELECT     | one cycle: select asserted, BA13/BA12/RW to select levels
//   WAIT_CMD   | cmd_ready high, waiting for a nibble (key_clk low)
//   SETUP      | SETTLE cycles of nibble setup before the clock edge
//   CLK_HI     | SETTLE cycles with key_clk high
//   CLK_LO     | SETTLE cycles with key_clk low, responder outputs settle
//   SAMPLE     | rsp_bits captured, rsp_valid high, step counted
//   FINISH     | done pulse, responder deselected
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start, n_steps     begin a sequence of n_steps steps (sampled on start)
//   abort              end the sequence now and deselect
//   cmd_valid/cmd_nib  host nibble for the next step; cmd_ready accepts it
//   rsp_valid/rsp_bits {RSP, SDRD} after each step
//   busy, done         sequence in progress / end-of-sequence pulse
//   key_*              responder socket pins; key_sdrd_i/key_rsp_i inputs
// ----------------------------------------------------------------------------
module cle_key_prober
    import cle_pkg::*;
#(
    parameter int unsigned RST_CYC = CLE_RST_CYC_DEF,
    parameter int unsigned SETTLE  = CLE_SETTLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] n_steps,
    input  logic       abort,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_nib,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [1:0] rsp_bits,
    output logic       busy,
    output logic       done,
    output logic       key_sel_n,
    output logic       key_ba13,
    output logic       key_ba12,
    output logic [3:0] key_nib,
    output logic       key_rw,
    output logic       key_clk,
    input  logic       key_sdrd_i,
    input  logic       key_rsp_i
);

    cle_state_e state;
    logic [5:0] n_steps_q;
    logic [5:0] step_cnt;
    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_expired;
    logic       go_finish;
    logic       sdrd_s1, sdrd_s2;
    logic       rsp_s1,  rsp_s2;

    // Responder lines are asynchronous to clk. The two-flop delay fits inside
    // the CLK_LO span when SETTLE >= 2; with SETTLE = 1 the captured pair lags
    // the key_clk edge it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdrd_s1 <= 1'b1;
            sdrd_s2 <= 1'b1;
            rsp_s1  <= 1'b1;
            rsp_s2  <= 1'b1;
        end else begin
            sdrd_s1 <= key_sdrd_i;
            sdrd_s2 <= sdrd_s1;
            rsp_s1  <= key_rsp_i;
            rsp_s2  <= rsp_s1;
        end
    end

    assign tmr_val = (state == ST_DESEL) ? 4'(RST_CYC) : 4'(SETTLE);

    cle_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // All routes into FINISH: abort from any active state, an empty sequence,
    // or the last step sampled.
    always_comb begin
        go_finish = 1'b0;
        if (abort && (state != ST_IDLE) && (state != ST_FINISH)) begin
            go_finish = 1'b1;
        end else if ((state == ST_SELECT) && (n_steps_q == 6'd0)) begin
            go_finish = 1'b1;
        end else if ((state == ST_SAMPLE) && (step_cnt == n_steps_q)) begin
            go_finish = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            n_steps_q <= 6'd0;
            step_cnt  <= 6'd0;
            tmr_load  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_bits  <= 2'b11;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_sel_n <= 1'b1;
            key_ba13  <= 1'b1;
            key_ba12  <= 1'b0;
            key_nib   <= 4'd0;
            key_rw    <= 1'b0;
            key_clk   <= 1'b0;
        end else begin
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            tmr_load  <= 1'b0;

            if (go_finish) begin
                // An in-flight step is dropped: key_clk forced low, no sample
                state     <= ST_FINISH;
                done      <= 1'b1;
                cmd_ready <= 1'b0;
                key_clk   <= 1'b0;
                key_sel_n <= 1'b1;
                key_ba13  <= 1'b1;
                key_ba12  <= 1'b0;
                key_rw    <= 1'b0;
                key_nib   <= 4'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // abort in the same cycle suppresses the start
                        if (start && !abort) begin
                            state     <= ST_DESEL;
                            busy      <= 1'b1;
                            n_steps_q <= n_steps;
                            step_cnt  <= 6'd0;
                            tmr_load  <= 1'b1;
                        end
                    end
                    ST_DESEL: begin
                        if (tmr_expired) begin
                            state     <= ST_SELECT;
                            key_sel_n <= 1'b0;
                            key_ba13  <= KEY_BA13_SEL;
                            key_ba12  <= KEY_BA12_SEL;
                            key_rw    <= KEY_RW_SEL;
                        end
                    end
                    ST_SELECT: begin
                        state     <= ST_WAIT_CMD;
                        cmd_ready <= 1'b1;
                    end
                    ST_WAIT_CMD: begin
                        if (cmd_valid) begin
                            state     <= ST_SETUP;
                            cmd_ready <= 1'b0;
                            key_nib   <= cmd_nib;
                            tmr_load  <= 1'b1;
                        end
                    end
                    ST_SETUP: begin
                        if (tmr_expired) begin
                            state    <= ST_CLK_HI;
                            key_clk  <= 1'b1;
                            tmr_load <= 1'b1;
                        end
                    end
                    ST_CLK_HI: begin
                        if (tmr_expired) begin
                            state    <= ST_CLK_LO;
                            key_clk  <= 1'b0;
                            tmr_load <= 1'b1;
                        end
                    end
                    ST_CLK_LO: begin
                        if (tmr_expired) begin
                            state     <= ST_SAMPLE;
                            rsp_bits  <= {rsp_s2, sdrd_s2};
                            rsp_valid <= 1'b1;
                            step_cnt  <= step_cnt + 6'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        // last-step case handled by go_finish
                        state     <= ST_WAIT_CMD;
                        cmd_ready <= 1'b1;
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cle_key_prober.sv
// ----------------------------------------------------------------------------
// tb_cle_key_prober
//   Drives cle_key_prober against a behavioural CLE0a1 responder and checks
//   the returned bit pairs against a history-based prediction of the
//   responder state, plus pin, timing and handshake behaviour.
// ----------------------------------------------------------------------------
module tb_cle_key_prober;

    localparam int RST_CYC = 4;
    localparam int SETTLE  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] n_steps = 6'd0;
    logic       abort = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_nib = 4'd0;
    logic       cmd_ready, rsp_valid, busy, done;
    logic [1:0] rsp_bits;
    logic       key_sel_n, key_ba13, key_ba12, key_rw, key_clk;
    logic [3:0] key_nib;
    logic       key_sdrd_i, key_rsp_i;

    int total = 0;
    int bad   = 0;
    int clk_rises = 0;
    int rsp_cnt   = 0;
    int done_cnt  = 0;
    logic [3:0] nib_at_clk = 4'd0;
    logic [3:0] hist[$];

    always #5 clk = ~clk;

    cle_key_prober #(.RST_CYC(RST_CYC), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_steps    (n_steps),
        .abort      (abort),
        .cmd_valid  (cmd_valid),
        .cmd_nib    (cmd_nib),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_bits   (rsp_bits),
        .busy       (busy),
        .done       (done),
        .key_sel_n  (key_sel_n),
        .key_ba13   (key_ba13),
        .key_ba12   (key_ba12),
        .key_nib    (key_nib),
        .key_rw     (key_rw),
        .key_clk    (key_clk),
        .key_sdrd_i (key_sdrd_i),
        .key_rsp_i  (key_rsp_i)
    );

    // Responder: clears while deselected, advances on each key_clk rise.
    // Undriven lines read high.
    logic [3:0] resp_st = 4'd0;
    always @(posedge key_clk or posedge key_sel_n) begin
        if (key_sel_n) resp_st <= 4'd0;
        else           resp_st <= 4'(resp_st * 5 + key_nib + 3);
    end
    assign key_sdrd_i = key_sel_n ? 1'b1 : resp_st[0];
    assign key_rsp_i  = key_sel_n ? 1'b1 : (resp_st[3] ^ resp_st[1]);

    always @(posedge key_clk) begin
        clk_rises++;
        nib_at_clk = key_nib;
    end

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (done)      done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {RSP, SDRD}: fold every nibble sent since selection from state 0
    function automatic logic [1:0] model_bits(input logic [3:0] q[$]);
        int st = 0;
        logic [3:0] s;
        foreach (q[i]) st = (st * 5 + int'(q[i]) + 3) % 16;
        s = 4'(st);
        return {s[3] ^ s[1], s[0]};
    endfunction

    task automatic start_seq(input int n);
        int g = 0;
        while (busy && g < 200) begin @(negedge clk); g++; end
        chk("idle_before_start", busy, 0);
        hist.delete();
        start = 1'b1;
        n_steps = 6'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic do_step(input logic [3:0] nib, input int gap);
        int lat;
        wait_ready();
        repeat (gap) @(negedge clk);
        chk("sel_lines_held", {key_sel_n, key_ba13, key_ba12, key_rw}, 4'b0011);
        cmd_valid = 1'b1;
        cmd_nib = nib;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("step_latency", lat, 3 * SETTLE + 1);
        hist.push_back(nib);
        chk("rsp_bits", {30'd0, rsp_bits}, {30'd0, model_bits(hist)});
        chk("nib_at_key_clk", {28'd0, nib_at_clk}, {28'd0, nib});
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 100) begin @(negedge clk); g++; end
        chk("done_pulse", done, 1);
        chk("desel_at_done", {key_sel_n, key_ba13, key_ba12, key_rw}, 4'b1100);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic wait_key_clk(input logic lvl);
        int g = 0;
        while (key_clk !== lvl && g < 100) begin @(negedge clk); g++; end
        chk("key_clk_level", key_clk, lvl);
    endtask

    initial begin
        int c0, r0, d0, k, v_clk, v_sel, n;

        // 1: reset state held every cycle
        repeat (4) begin
            @(negedge clk);
            chk("rst_sel_n", key_sel_n, 1);
            chk("rst_key_clk", key_clk, 0);
            chk("rst_rsp_bits", rsp_bits, 2'b11);
            chk("rst_busy", busy, 0);
        end
        chk("rst_addr", {key_ba13, key_ba12, key_nib, key_rw}, 7'b1000000);
        chk("rst_pulses", {done, rsp_valid, cmd_ready}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {busy, key_sel_n}, 2'b01);

        // 2: three steps 2, A, 9; start while busy must be ignored
        c0 = clk_rises; r0 = rsp_cnt; d0 = done_cnt;
        start_seq(3);
        do_step(4'h2, 0);
        start = 1'b1; n_steps = 6'd1;
        @(negedge clk);
        start = 1'b0;
        do_step(4'hA, 0);
        do_step(4'h9, 0);
        wait_done();
        chk("seq3_key_clk_pulses", clk_rises - c0, 3);
        chk("seq3_rsp_valid", rsp_cnt - r0, 3);
        chk("seq3_done_count", done_cnt - d0, 1);

        // 3: nibble withheld 20 cycles after step 1
        start_seq(3);
        do_step(4'($urandom_range(0, 15)), 0);
        wait_ready();
        v_clk = 0; v_sel = 0;
        repeat (20) begin
            @(negedge clk);
            if (key_clk !== 1'b0)   v_clk++;
            if (key_sel_n !== 1'b0) v_sel++;
        end
        chk("hold_key_clk_low", v_clk, 0);
        chk("hold_selected", v_sel, 0);
        do_step(4'($urandom_range(0, 15)), 0);
        do_step(4'($urandom_range(0, 15)), 0);
        wait_done();

        // 4: abort during CLK_HI of step 2
        d0 = done_cnt;
        start_seq(3);
        do_step(4'($urandom_range(0, 15)), 0);
        wait_ready();
        cmd_valid = 1'b1; cmd_nib = 4'h5;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_key_clk(1'b1);
        r0 = rsp_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sel_n", key_sel_n, 1);
        chk("abort_key_clk", key_clk, 0);
        chk("abort_done", done, 1);
        @(negedge clk);
        chk("abort_busy_low", busy, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        chk("abort_done_count", done_cnt - d0, 1);

        // abort together with start in IDLE: nothing starts
        start = 1'b1; abort = 1'b1; n_steps = 6'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_beats_start", {busy, key_sel_n}, 2'b01);

        // 5: empty sequence
        c0 = clk_rises; r0 = rsp_cnt;
        start = 1'b1; n_steps = 6'd0;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 50) begin @(negedge clk); k++; end
        chk("nsteps0_done_latency", k, RST_CYC + 2);
        chk("nsteps0_no_key_clk", clk_rises - c0, 0);
        chk("nsteps0_no_rsp", rsp_cnt - r0, 0);
        @(negedge clk);
        chk("nsteps0_busy_low", busy, 0);

        // 6: reset during CLK_LO, then a fresh sequence from responder state 0
        start_seq(3);
        do_step(4'($urandom_range(0, 15)), 0);
        wait_ready();
        cmd_valid = 1'b1; cmd_nib = 4'hC;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_key_clk(1'b1);
        wait_key_clk(1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_sel_n", key_sel_n, 1);
        chk("midrst_key_clk", key_clk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_bits", rsp_bits, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_seq(2);
        do_step(4'($urandom_range(0, 15)), 0);
        do_step(4'($urandom_range(0, 15)), 1);
        wait_done();

        // randomized sequences
        for (int s = 0; s < 5; s++) begin
            n = int'($urandom_range(1, 6));
            c0 = clk_rises; r0 = rsp_cnt;
            start_seq(n);
            for (int i = 0; i < n; i++)
                do_step(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            wait_done();
            chk("rand_key_clk_pulses", clk_rises - c0, n);
            chk("rand_rsp_valid", rsp_cnt - r0, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
